// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: select codes, FSM state type,
// divide-by-zero result constant and the EXEC-length helper.
package alu_sched_pkg;

   localparam logic [2:0] ADD  = 3'b000;
   localparam logic [2:0] SUB  = 3'b001;
   localparam logic [2:0] MUL  = 3'b010;
   localparam logic [2:0] DIV  = 3'b011;
   localparam logic [2:0] MOVB = 3'b100;
   localparam logic [2:0] SWAP = 3'b101;
   localparam logic [2:0] ANDI = 3'b110;
   localparam logic [2:0] ORI  = 3'b111;

   localparam logic [15:0] ERR_QUOT = 16'h7FFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Number of EXEC-state cycles an operation occupies.
   function automatic logic [3:0] exec_cycles(input logic [2:0]  sel,
                                              input int unsigned mul_c,
                                              input int unsigned div_c);
      logic [3:0] n;
      n = 4'd1;
      if (sel == MUL)      n = 4'(mul_c);
      else if (sel == DIV) n = 4'(div_c);
      return n;
   endfunction

endpackage

// File: rtl/alu_sched_rr_arb.sv
// Two-way round-robin arbiter for the scheduler's requester ports.
// The pointer remembers the last granted requester and moves only on a handshake.
module alu_sched_rr_arb
   import alu_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] valid_i,
   output logic [1:0] ready_o,
   output logic       gnt_id_o
);

   logic last_q;
   logic last_d;
   logic hs;

   always_comb begin
      ready_o  = 2'b00;
      gnt_id_o = 1'b0;
      if (en_i) begin
         // With both requesting, the one not served last wins.
         if (valid_i == 2'b11) gnt_id_o = ~last_q;
         else                  gnt_id_o = valid_i[1];
         if (|valid_i) ready_o = gnt_id_o ? 2'b10 : 2'b01;
      end
   end

   assign hs     = |(valid_i & ready_o);
   assign last_d = hs ? gnt_id_o : last_q;

   // Reset value 1 makes requester 0 win the first contention.
   always_ff @(posedge clk) begin
      if (rst) last_q <= 1'b1;
      else     last_q <= last_d;
   end

endmodule

// File: rtl/alu_sched.sv
// Two-port scheduler in front of a shared combinational ALU (IDLE/EXEC/RESP).
// Optional feature: ALU_SCHED_DIVZERO_EN short-circuits divide-by-zero into an error response.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 2,
   parameter int unsigned DIV_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic signed [15:0] req0_a,
   input  logic signed [15:0] req0_b,
   input  logic        [2:0]  req0_sel,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic signed [15:0] req1_a,
   input  logic signed [15:0] req1_b,
   input  logic        [2:0]  req1_sel,
   output logic signed [15:0] alu_a,
   output logic signed [15:0] alu_b,
   output logic        [2:0]  alu_sel,
   input  logic signed [15:0] alu_op1,
   input  logic signed [15:0] alu_op2,
   input  logic signed [15:0] alu_r15,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic        [15:0] rsp_op1,
   output logic        [15:0] rsp_op2,
   output logic        [15:0] rsp_r15,
   output logic               rsp_err,
   output logic               busy,
   output logic        [1:0]  dbg_state_o
);

   // Handshakes: a request transfers on reqN_valid & reqN_ready at a rising
   // edge; a response transfers on rsp_valid & rsp_ready. Valid never waits
   // on ready, and rsp_* stay frozen while rsp_valid is high and unaccepted.

   state_t             state_q, state_d;
   logic        [3:0]  cnt_q,   cnt_d;
   logic signed [15:0] a_q,     a_d;
   logic signed [15:0] b_q,     b_d;
   logic        [2:0]  sel_q,   sel_d;
   logic               id_q,    id_d;
   logic        [15:0] op1_q,   op1_d;
   logic        [15:0] op2_q,   op2_d;
   logic        [15:0] r15_q,   r15_d;
`ifdef ALU_SCHED_DIVZERO_EN
   logic               err_q,   err_d;
`endif

   logic        [1:0]  arb_ready;
   logic               gnt_id;
   logic               hs;
   logic signed [15:0] a_in;
   logic signed [15:0] b_in;
   logic        [2:0]  sel_in;

   alu_sched_rr_arb u_arb (
      .clk      (clk),
      .rst      (rst),
      .en_i     ((state_q == ST_IDLE) && !rst),
      .valid_i  ({req1_valid, req0_valid}),
      .ready_o  (arb_ready),
      .gnt_id_o (gnt_id)
   );

   assign req0_ready = arb_ready[0];
   assign req1_ready = arb_ready[1];
   assign hs         = (req0_valid & req0_ready) | (req1_valid & req1_ready);

   assign a_in   = gnt_id ? req1_a   : req0_a;
   assign b_in   = gnt_id ? req1_b   : req0_b;
   assign sel_in = gnt_id ? req1_sel : req0_sel;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sel_d   = sel_q;
      id_d    = id_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      r15_d   = r15_q;
`ifdef ALU_SCHED_DIVZERO_EN
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               a_d     = a_in;
               b_d     = b_in;
               sel_d   = sel_in;
               id_d    = gnt_id;
               cnt_d   = exec_cycles(sel_in, MUL_CYCLES, DIV_CYCLES) - 4'd1;
               state_d = ST_EXEC;
`ifdef ALU_SCHED_DIVZERO_EN
               err_d   = 1'b0;
               // Divide-by-zero bypasses the ALU and answers next cycle.
               if ((sel_in == DIV) && (b_in == 16'sd0)) begin
                  cnt_d   = 4'd0;
                  op1_d   = ERR_QUOT;
                  op2_d   = 16'd0;
                  r15_d   = a_in;
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end
`endif
            end
         end
         ST_EXEC: begin
            if (cnt_q == 4'd0) begin
               op1_d   = alu_op1;
               op2_d   = alu_op2;
               r15_d   = alu_r15;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         a_q     <= 16'sd0;
         b_q     <= 16'sd0;
         sel_q   <= 3'd0;
         id_q    <= 1'b0;
         op1_q   <= 16'd0;
         op2_q   <= 16'd0;
         r15_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         id_q    <= id_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         r15_q   <= r15_d;
      end
   end

`ifdef ALU_SCHED_DIVZERO_EN
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end
   assign rsp_err = err_q & ~rst;
`else
   assign rsp_err = 1'b0;
`endif

   // Status outputs are forced low during the reset cycle itself.
   assign rsp_valid   = (state_q == ST_RESP) && !rst;
   assign busy        = (state_q != ST_IDLE) && !rst;
   assign rsp_id      = id_q & ~rst;
   assign rsp_op1     = op1_q;
   assign rsp_op2     = op2_q;
   assign rsp_r15     = r15_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_sel     = sel_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: transaction-level model with per-cycle compare plus
// directed scenarios with hand-computed results. Honours ALU_SCHED_DIVZERO_EN.
module tb_alu_sched;
   import alu_sched_pkg::*;

   localparam int MUL_C = 2;
   localparam int DIV_C = 4;

   typedef struct packed {
      logic        id;
      logic [15:0] op1;
      logic [15:0] op2;
      logic [15:0] r15;
      logic        err;
   } rsp_t;

   typedef struct {
      bit          port;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  sel;
   } vec_t;

   logic               clk;
   logic               rst;
   logic               req0_valid, req1_valid;
   logic               req0_ready, req1_ready;
   logic signed [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        [2:0]  req0_sel, req1_sel;
   logic signed [15:0] alu_a, alu_b;
   logic        [2:0]  alu_sel;
   logic signed [15:0] alu_op1, alu_op2, alu_r15;
   logic               rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic        [15:0] rsp_op1, rsp_op2, rsp_r15;
   logic        [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   alu_sched #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_r15(alu_r15),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_op1(rsp_op1), .rsp_op2(rsp_op2), .rsp_r15(rsp_r15), .rsp_err(rsp_err),
      .busy(busy), .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference ALU: {op1, op2, r15} ----------------
   function automatic logic [47:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
      int ai, bi, p;
      logic [15:0] o1, o2, r;
      ai = int'($signed(a));
      bi = int'($signed(b));
      o1 = 16'd0;
      o2 = a ^ b;
      r  = 16'd0;
      case (s)
         ADD:  o1 = 16'(ai + bi);
         SUB:  o1 = 16'(ai - bi);
         MUL:  begin p = ai * bi; o1 = p[15:0]; r = p[31:16]; end
         DIV:  begin
            if (bi == 0) begin o1 = 16'hFFFF; r = a; end
            else begin o1 = 16'(ai / bi); r = 16'(ai % bi); end
         end
         MOVB: o1 = b;
         SWAP: begin o1 = b; o2 = a; end
         ANDI: o1 = a & b;
         default: o1 = a | b;
      endcase
      return {o1, o2, r};
   endfunction

   always_comb {alu_op1, alu_op2, alu_r15} = ref_alu(alu_a, alu_b, alu_sel);

   function automatic rsp_t model_rsp(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
      rsp_t e;
      logic [47:0] r;
      r     = ref_alu(a, b, s);
      e.id  = id;
      e.op1 = r[47:32];
      e.op2 = r[31:16];
      e.r15 = r[15:0];
      e.err = 1'b0;
`ifdef ALU_SCHED_DIVZERO_EN
      if (s == DIV && b == 16'd0) begin
         e.op1 = 16'h7FFF; e.op2 = 16'd0; e.r15 = a; e.err = 1'b1;
      end
`endif
      return e;
   endfunction

   // Cycles from request handshake to first rsp_valid.
   function automatic int model_lat(input logic [2:0] s, input logic [15:0] b);
`ifdef ALU_SCHED_DIVZERO_EN
      if (s == DIV && b == 16'd0) return 1;
`endif
      if (s == MUL) return 1 + MUL_C;
      if (s == DIV) return 1 + DIV_C;
      return 2;
   endfunction

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard / per-cycle compare ----------------
   rsp_t        exp_q[$];
   bit          m_busy = 1'b0;
   bit          m_last = 1'b1;
   int          m_due  = 0;
   logic [15:0] m_a = '0, m_b = '0;
   logic [2:0]  m_sel = '0;

   always @(negedge clk) begin
      if (rst) begin
         chk(!req0_ready && !req1_ready, "rst_ready", {req1_ready, req0_ready}, 0);
         chk(!rsp_valid && !busy && !rsp_err && !rsp_id, "rst_status",
             {rsp_valid, busy, rsp_err, rsp_id}, 0);
         exp_q.delete();
         m_busy = 1'b0; m_last = 1'b1;
         m_a = '0; m_b = '0; m_sel = '0;
      end else begin
         chk(alu_a == m_a && alu_b == m_b && alu_sel == m_sel, "alu_regs", alu_a, m_a);
         if (!m_busy) begin
            int w;
            w = -1;
            if (req0_valid && req1_valid) w = m_last ? 0 : 1;
            else if (req0_valid)          w = 0;
            else if (req1_valid)          w = 1;
            chk(req0_ready == (w == 0), "arb_ready0", req0_ready, w == 0);
            chk(req1_ready == (w == 1), "arb_ready1", req1_ready, w == 1);
            chk(!busy && !rsp_valid, "idle_status", {busy, rsp_valid}, 0);
            if (w >= 0) begin
               m_a   = (w == 1) ? req1_a : req0_a;
               m_b   = (w == 1) ? req1_b : req0_b;
               m_sel = (w == 1) ? req1_sel : req0_sel;
               exp_q.push_back(model_rsp(w[0], m_a, m_b, m_sel));
               m_due  = cyc + model_lat(m_sel, m_b);
               m_busy = 1'b1;
               m_last = w[0];
            end
         end else begin
            chk(!req0_ready && !req1_ready, "ready_when_busy", {req1_ready, req0_ready}, 0);
            chk(busy, "busy", busy, 1);
            if (cyc < m_due) begin
               chk(!rsp_valid, "rsp_early", rsp_valid, 0);
            end else begin
               chk(rsp_valid, "rsp_valid", rsp_valid, 1);
               if (rsp_valid && exp_q.size() > 0) begin
                  chk(rsp_id  == exp_q[0].id,  "rsp_id",  rsp_id,  exp_q[0].id);
                  chk(rsp_op1 == exp_q[0].op1, "rsp_op1", rsp_op1, exp_q[0].op1);
                  chk(rsp_op2 == exp_q[0].op2, "rsp_op2", rsp_op2, exp_q[0].op2);
                  chk(rsp_r15 == exp_q[0].r15, "rsp_r15", rsp_r15, exp_q[0].r15);
                  chk(rsp_err == exp_q[0].err, "rsp_err", rsp_err, exp_q[0].err);
                  if (rsp_ready) begin
                     void'(exp_q.pop_front());
                     m_busy = 1'b0;
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic issue(input bit port, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] sel, output int hs_cyc);
      if (port) begin req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1; end
      else      begin req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1; end
      hs_cyc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (port ? req1_ready : req0_ready) begin hs_cyc = cyc; break; end
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk(hs_cyc >= 0, "hs_timeout", hs_cyc, 0);
   endtask

   task automatic wait_rsp(output int rc);
      rc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid) begin rc = cyc; break; end
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      @(posedge clk); #1;
   endtask

   // ---------------- directed scenarios ----------------
   vec_t vecs[6] = '{
      '{1'b1, 16'd3,     16'hFFF8, MOVB},
      '{1'b0, 16'h1234,  16'h00FF, SWAP},
      '{1'b1, 16'h0F0F,  16'h00FF, ANDI},
      '{1'b0, 16'h0F00,  16'h00F0, ORI},
      '{1'b1, 16'hFF9C,  16'hFFFD, DIV},
      '{1'b0, 16'hFFEC,  16'h0028, MUL}
   };

   initial begin
      int n, r, gr, seen;
      logic        gq[$];
      logic        iq[$];
      logic [15:0] oq[$];

      rst = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk(dbg_state == ST_IDLE, "reset_state", dbg_state, ST_IDLE);
      chk(rsp_op1 == 16'd0 && rsp_r15 == 16'd0, "reset_data", rsp_op1, 0);
      @(posedge clk); #1;

      // ADD 5+7: response two cycles after the handshake, re-accept one later
      rsp_ready = 1'b1;
      issue(1'b0, 16'd5, 16'd7, ADD, n);
      wait_rsp(r);
      chk(r - n == 2, "add_latency", r - n, 2);
      chk(rsp_op1 == 16'd12, "add_op1", rsp_op1, 12);
      chk(rsp_id == 1'b0, "add_id", rsp_id, 0);
      @(posedge clk); #1;
      req0_a = 16'd1; req0_b = 16'd1; req0_sel = ADD; req0_valid = 1'b1;
      @(negedge clk);
      chk(req0_ready && (cyc == n + 3), "add_reissue", cyc - n, 3);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_idle();

      // round-robin with both requesters continuously valid
      do_reset();
      req0_a = 16'd10;   req0_b = 16'd3; req0_sel = SUB; req0_valid = 1'b1;
      req1_a = 16'hFFFC; req1_b = 16'd6; req1_sel = SUB; req1_valid = 1'b1;
      for (int i = 0; i < 60 && iq.size() < 4; i++) begin
         @(negedge clk);
         if (req0_ready) gq.push_back(1'b0);
         if (req1_ready) gq.push_back(1'b1);
         if (rsp_valid && rsp_ready) begin iq.push_back(rsp_id); oq.push_back(rsp_op1); end
         @(posedge clk); #1;
         if (gq.size() >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk(gq.size() == 4 && iq.size() == 4, "rr_count", iq.size(), 4);
      for (int k = 0; k < 4; k++) begin
         chk(k < gq.size() && gq[k] == k[0], "rr_grant", (k < gq.size()) ? gq[k] : -1, k % 2);
         chk(k < iq.size() && iq[k] == k[0], "rr_rsp_id", (k < iq.size()) ? iq[k] : -1, k % 2);
      end
      chk(oq.size() > 1 && oq[0] == 16'd7 && oq[1] == 16'hFFF6, "rr_sub_results",
          (oq.size() > 1) ? oq[1] : -1, 16'hFFF6);
      wait_idle();

      // DIV -7 / 2
      issue(1'b0, 16'hFFF9, 16'd2, DIV, n);
      wait_rsp(r);
      chk(r - n == 5, "div_latency", r - n, 5);
      chk(rsp_op1 == 16'hFFFD, "div_quot", rsp_op1, 16'hFFFD);
      chk(rsp_r15 == 16'hFFFF, "div_rem", rsp_r15, 16'hFFFF);
      @(posedge clk); #1;
      wait_idle();

      // MUL 300*300 with rsp_ready low for five cycles while req0 waits
      rsp_ready = 1'b0;
      issue(1'b1, 16'd300, 16'd300, MUL, n);
      wait_rsp(r);
      chk(r - n == 3, "mul_latency", r - n, 3);
      gr = 0;
      req0_a = 16'd2; req0_b = 16'd3; req0_sel = ADD;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         if (i == 1) req0_valid = 1'b1;
         if (i == 5) rsp_ready = 1'b1;
         @(negedge clk);
         chk(rsp_valid && rsp_op1 == 16'h5F90 && rsp_r15 == 16'h0001, "mul_hold", rsp_op1, 16'h5F90);
         if (req0_ready || req1_ready) gr++;
      end
      chk(gr == 0, "mul_no_grant", gr, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk(req0_ready, "grant_after_rsp", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_idle();

      // reset during the second EXEC cycle of a DIV
      issue(1'b0, 16'd100, 16'd7, DIV, n);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk(dbg_state == ST_IDLE && !busy, "abort_idle", dbg_state, ST_IDLE);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk(seen == 0, "abort_no_rsp", seen, 0);
      @(posedge clk); #1;

      // remaining selects, checked by the scoreboard
      for (int i = 0; i < 6; i++) begin
         issue(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].sel, n);
         wait_idle();
      end

      // divide by zero
      issue(1'b0, 16'd9, 16'd0, DIV, n);
      wait_rsp(r);
`ifdef ALU_SCHED_DIVZERO_EN
      chk(r - n == 1, "dz_latency", r - n, 1);
      chk(rsp_err == 1'b1, "dz_err", rsp_err, 1);
      chk(rsp_op1 == 16'h7FFF, "dz_op1", rsp_op1, 16'h7FFF);
`else
      chk(r - n == 5, "dz_latency", r - n, 5);
      chk(rsp_err == 1'b0, "dz_err", rsp_err, 0);
      chk(rsp_op1 == 16'hFFFF, "dz_op1", rsp_op1, 16'hFFFF);
`endif
      chk(rsp_r15 == 16'd9, "dz_r15", rsp_r15, 9);
      @(posedge clk); #1;
      wait_idle();

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
